fp_align_addsub_pipe: RTL and testbench

- Three-stage pipelined front end of the FP adder/subtractor (IEEE-754 single precision).
- Takes operands a, b and the add/sub select, then does magnitude swap, exponent alignment and significand add/subtract.
- Its 25-bit raw significand and exponent feed priority_encoder directly for normalization.
- Replaces the combinational front half of the adder so the Newton-Raphson divider datapath can be pipelined.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_align_shift.sv | 24 ++
 rtl/fp_align_addsub_pipe.sv | 142 ++++++++++++++
 tb/tb_fp_align_addsub_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared widths, IEEE-754 single field layout and pipeline stage records
// for the FP add/sub front end.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 1;
    localparam int RAW_W = MAN_W + 2;
    localparam int BIAS  = 127;

    localparam logic [EXP_W-1:0] EXP_INF = '1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             eff_add;
        logic             exception;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig_a;
        logic [SIG_W-1:0] sig_b;
        logic             sticky;
    } stage_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [RAW_W-1:0] significand;
        logic             is_sub;
        logic             sticky;
        logic             exception;
    } result_t;

endpackage

// File: rtl/fp_align_shift.sv
// Right shifter for the smaller significand; sticky collects every bit
// that falls off the bottom, saturating to "all shifted out" at d >= SIG_W.
module fp_align_shift
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] sig,
    input  logic [EXP_W-1:0] d,
    output logic [SIG_W-1:0] shifted,
    output logic             sticky
);

    logic [2*SIG_W-1:0] ext;

    always_comb begin
        ext     = {sig, {SIG_W{1'b0}}} >> d;
        shifted = ext[2*SIG_W-1:SIG_W];
        sticky  = |ext[SIG_W-1:0];
        if (d >= EXP_W'(SIG_W)) begin
            shifted = '0;
            sticky  = |sig;
        end
    end

endmodule

// File: rtl/fp_align_addsub_pipe.sv
// Three-stage FP add/sub front end: swap/decode, align, raw add/sub.
// Raw significand and exponent go straight to the normalizing priority encoder.
module fp_align_addsub_pipe
    import fp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   add_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic [EXP_W-1:0]       out_exp,
    output logic [MAN_W+1:0]       out_significand,
    output logic                   out_is_sub,
    output logic                   out_sticky,
    output logic                   out_exception
);

    stage_t           s1_q, s1_d, s2_q, s2_d;
    result_t          res_q, res_d;
    logic [EXP_W-1:0] exp_b_q, exp_b_d;

    logic en1, en2, en3;
    fp_t  fa, fb, op_a, op_b;
    logic swapped;

    logic [EXP_W-1:0] d_s2;
    logic [SIG_W-1:0] sig_b_al;
    logic             sh_sticky;
    logic [SIG_W:0]   sum_s3;
    logic [SIG_W-1:0] diff_s3;

    assign en3      = out_ready || !res_q.valid;
    assign en2      = en3 || !s2_q.valid;
    assign en1      = en2 || !s1_q.valid;
    assign in_ready = en1;

    // S1: order by magnitude so op_a is never smaller than op_b
    always_comb begin
        fa      = a;
        fb      = b;
        swapped = {fa.exp, fa.man} < {fb.exp, fb.man};
        op_a    = swapped ? fb : fa;
        op_b    = swapped ? fa : fb;
        s1_d    = s1_q;
        exp_b_d = exp_b_q;
        if (en1) begin
            s1_d.valid = in_valid;
            if (in_valid) begin
                s1_d.exception = (fa.exp == EXP_INF) || (fb.exp == EXP_INF);
                s1_d.sticky    = 1'b0;
                if (s1_d.exception) begin
                    s1_d.sign    = 1'b0;
                    s1_d.eff_add = 1'b1;
                    s1_d.exp     = '0;
                    s1_d.sig_a   = '0;
                    s1_d.sig_b   = '0;
                    exp_b_d      = '0;
                end else begin
                    s1_d.eff_add = add_sub ? (op_a.sign ^ op_b.sign) : ~(op_a.sign ^ op_b.sign);
                    s1_d.sign    = (add_sub && swapped) ? ~op_a.sign : op_a.sign;
                    s1_d.exp     = op_a.exp;
                    s1_d.sig_a   = {|op_a.exp, op_a.man};
                    s1_d.sig_b   = {|op_b.exp, op_b.man};
                    exp_b_d      = op_b.exp;
                end
            end
        end
    end

    // S2: align the smaller operand
    assign d_s2 = s1_q.exp - exp_b_q;

    fp_align_shift u_align_shift (
        .sig     (s1_q.sig_b),
        .d       (d_s2),
        .shifted (sig_b_al),
        .sticky  (sh_sticky)
    );

    always_comb begin
        s2_d = s2_q;
        if (en2) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.sign      = s1_q.sign;
                s2_d.eff_add   = s1_q.eff_add;
                s2_d.exception = s1_q.exception;
                s2_d.exp       = s1_q.exp;
                s2_d.sig_a     = s1_q.sig_a;
                s2_d.sig_b     = sig_b_al;
                s2_d.sticky    = sh_sticky | s1_q.sticky;
            end
        end
    end

    // S3: subtract never borrows, so bit SIG_W is a fixed marker for the encoder
    assign sum_s3  = {1'b0, s2_q.sig_a} + {1'b0, s2_q.sig_b};
    assign diff_s3 = s2_q.sig_a - s2_q.sig_b;

    always_comb begin
        res_d = res_q;
        if (en3) begin
            res_d.valid = s2_q.valid;
            if (s2_q.valid) begin
                res_d.sign        = s2_q.sign;
                res_d.exp         = s2_q.exp;
                res_d.significand = s2_q.eff_add ? sum_s3 : {1'b1, diff_s3};
                res_d.is_sub      = ~s2_q.eff_add;
                res_d.sticky      = s2_q.sticky;
                res_d.exception   = s2_q.exception;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            res_q   <= '0;
            exp_b_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            res_q   <= res_d;
            exp_b_q <= exp_b_d;
        end
    end

    assign out_valid       = res_q.valid;
    assign out_sign        = res_q.sign;
    assign out_exp         = res_q.exp;
    assign out_significand = res_q.significand;
    assign out_is_sub      = res_q.is_sub;
    assign out_sticky      = res_q.sticky;
    assign out_exception   = res_q.exception;

endmodule

// File: tb/tb_fp_align_addsub_pipe.sv
// Scoreboard bench for fp_align_addsub_pipe: directed cases, random traffic
// with random backpressure, full-pipe stall and mid-stream reset.
module tb_fp_align_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        add_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [24:0] out_significand;
    logic        out_is_sub;
    logic        out_sticky;
    logic        out_exception;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] sig;
        logic        is_sub;
        logic        sticky;
        logic        exc;
    } res_t;

    res_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ready_mode = 0;

    fp_align_addsub_pipe dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a               (a),
        .b               (b),
        .add_sub         (add_sub),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sign        (out_sign),
        .out_exp         (out_exp),
        .out_significand (out_significand),
        .out_is_sub      (out_is_sub),
        .out_sticky      (out_sticky),
        .out_exception   (out_exception)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: real-number view of the operation, expressed on integer significands
    function automatic res_t model(input logic [31:0] av, input logic [31:0] bv, input logic as);
        res_t        r;
        logic [31:0] pa, pb;
        logic        swap;
        longint      ea, eb, ma, mb, d, al;
        logic        st;
        r = '0;
        if (av[30:23] == 8'hFF || bv[30:23] == 8'hFF) begin
            r.exc = 1'b1;
            return r;
        end
        swap = av[30:0] < bv[30:0];
        pa = swap ? bv : av;
        pb = swap ? av : bv;
        ea = longint'(pa[30:23]);
        eb = longint'(pb[30:23]);
        ma = longint'(pa[22:0]) + ((ea != 0) ? 64'sd8388608 : 64'sd0);
        mb = longint'(pb[22:0]) + ((eb != 0) ? 64'sd8388608 : 64'sd0);
        d  = ea - eb;
        if (d >= 24) begin
            al = 0;
            st = (mb != 0);
        end else begin
            al = mb >> d;
            st = (mb % (64'sd1 << d)) != 0;
        end
        r.is_sub = pa[31] ^ pb[31] ^ as;
        r.sign   = (as && swap) ? ~pa[31] : pa[31];
        r.exp    = pa[30:23];
        r.sig    = r.is_sub ? 25'(64'sd16777216 + ma - al) : 25'(ma + al);
        r.sticky = st;
        return r;
    endfunction

    function automatic res_t cur_out();
        res_t r;
        r = {out_sign, out_exp, out_significand, out_is_sub, out_sticky, out_exception};
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard: push on input transfer, pop/compare on output transfer
    initial begin
        res_t held;
        res_t got;
        res_t req;
        logic hold_prev;
        hold_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                hold_prev = 1'b0;
            end else begin
                got = cur_out();
                if (hold_prev && out_valid)
                    chk("hold_stable", 64'(got), 64'(held));
                hold_prev = out_valid && !out_ready;
                held = got;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 64'(got), 64'h0);
                        if (got == '0) begin
                            n_fail++;
                            $display("FAIL unexpected_output: actual=valid required=idle");
                        end
                    end else begin
                        req = q.pop_front();
                        chk("scoreboard", 64'(got), 64'(req));
                    end
                end
                if (in_valid && in_ready)
                    q.push_back(model(a, b, add_sub));
            end
        end
    end

    task automatic align_clk();
        @(posedge clk);
        #1;
    endtask

    // Caller must be at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic as);
        int t;
        in_valid = 1'b1;
        a = av;
        b = bv;
        add_sub = as;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual=in_ready low required=accept");
        end
        align_clk();
    endtask

    task automatic directed(input string nm, input logic [31:0] av, input logic [31:0] bv,
                            input logic as, input res_t req);
        int t;
        align_clk();
        send(av, bv, as);
        in_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 20);
        chk({nm, "_latency"}, 64'(t), 64'd3);
        chk(nm, 64'(cur_out()), 64'(req));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_b(input logic [31:0] av);
        logic [31:0] bv;
        int          k;
        bv = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: bv = av ^ 32'h8000_0000;
            default: begin
                k = $urandom_range(0, 30);
                bv[30:23] = (k > int'(av[30:23])) ? 8'd0 : 8'(int'(av[30:23]) - k);
            end
        endcase
        return bv;
    endfunction

    initial begin
        logic [31:0] ra;
        int          t;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_data", 64'(cur_out()), 64'd0);
        align_clk();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        ready_mode = 0;
        directed("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, {1'b0, 8'h7F, 25'h1000000, 1'b0, 1'b0, 1'b0});
        directed("three_minus_1", 32'h40400000, 32'h3F800000, 1'b1, {1'b0, 8'h80, 25'h1800000, 1'b1, 1'b0, 1'b0});
        directed("one_minus_3",   32'h3F800000, 32'h40400000, 1'b1, {1'b1, 8'h80, 25'h1800000, 1'b1, 1'b0, 1'b0});
        directed("d24_sticky",    32'h4B800000, 32'h3F800000, 1'b0, {1'b0, 8'h97, 25'h0800000, 1'b0, 1'b1, 1'b0});
        directed("inf_exception", 32'h7F800000, 32'h3F800000, 1'b0, {1'b0, 8'h00, 25'h0000000, 1'b0, 1'b0, 1'b1});
        directed("after_exc",     32'h3F800000, 32'h3F800000, 1'b0, {1'b0, 8'h7F, 25'h1000000, 1'b0, 1'b0, 1'b0});
        directed("equal_sub",     32'h40A00000, 32'h40A00000, 1'b1, {1'b0, 8'h81, 25'h1000000, 1'b1, 1'b0, 1'b0});

        // Random traffic with random backpressure
        ready_mode = 2;
        align_clk();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                align_clk();
            end else begin
                ra = $urandom;
                if ($urandom_range(0, 15) == 0) ra[30:23] = 8'hFF;
                send(ra, rand_b(ra), 1'($urandom_range(0, 1)));
            end
        end
        in_valid = 1'b0;
        ready_mode = 0;
        wait_drain();

        // Full pipe stall: 3 ops held, 4th waits
        ready_mode = 1;
        align_clk();
        align_clk();
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0);
                send(32'h40400000, 32'h3F800000, 1'b1);
                send(32'h3F800000, 32'h40400000, 1'b1);
                send(32'h4B800000, 32'h3F800000, 1'b0);
                in_valid = 1'b0;
            end
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!out_valid && t < 50);
                chk("stall_first_valid", 64'(out_valid), 64'd1);
                @(negedge clk);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                repeat (5) @(negedge clk);
                chk("stall_in_ready_late", 64'(in_ready), 64'd0);
                chk("stall_queue_depth", 64'(q.size()), 64'd3);
                ready_mode = 0;
            end
        join
        wait_drain();

        // Mid-stream reset flushes in-flight ops
        align_clk();
        send(32'h40400000, 32'h3F800000, 1'b1);
        send(32'h4B800000, 32'h3F800000, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        align_clk();
        rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_data", 64'(out_significand), 64'd0);
        repeat (10) @(negedge clk);
        directed("post_reset", 32'h40400000, 32'h3F800000, 1'b1, {1'b0, 8'h80, 25'h1800000, 1'b1, 1'b0, 1'b0});
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
